// File: rtl/f1_start_ctrl_pkg.sv
// Shared types and constants for the F1 start controller.
package f1_pkg;

  typedef enum logic [1:0] {IDLE, LIGHTS_UP, HOLD, TIMING} f1_ctrl_state_t;

  localparam logic [6:0] LFSR_SEED = 7'h01;
  localparam logic [6:0] LFSR_TAPS = 7'b1100000;   // x^7 + x^6 + 1

  // Shift left; the feedback bit is the parity of the tapped bits.
  function automatic logic [6:0] lfsr_next(input logic [6:0] s);
    return {s[5:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/f1_start_ctrl_if.sv
// Start-controller signal bundle: driver/host side is master, controller is slave.
interface f1_start_ctrl_if #(parameter int RT_W = 16);
  logic            trigger;
  logic            react;
  logic [7:0]      data_out;
  logic            busy;
  logic            rt_valid;
  logic [RT_W-1:0] rt_count;
  logic            jump_start;

  modport master (output trigger, react,
                  input  data_out, busy, rt_valid, rt_count, jump_start);
  modport slave  (input  trigger, react,
                  output data_out, busy, rt_valid, rt_count, jump_start);
endinterface

// File: rtl/f1_start_ctrl_lfsr7.sv
// Free-running 7-bit maximal-length LFSR supplying the random hold delay.
module lfsr7
  import f1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] q
);

  logic [6:0] q_q, q_d;

  // Next value from the shared polynomial helper.
  always_comb q_d = lfsr_next(q_q);

  // Advance every cycle, including while the controller is idle.
  always_ff @(posedge clk) begin
    if (rst) q_q <= LFSR_SEED;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/f1_start_ctrl.sv
// F1 light-bar start sequencer: lamp build-up, random hold, reaction timing.
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int RT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  f1_start_ctrl_if.slave bus
);

  localparam int             TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [RT_W-1:0] RT_MAX   = '1;

  f1_ctrl_state_t  state_q;
  logic [TW-1:0]   tick_q;
  logic [6:0]      hold_q;
  logic [7:0]      data_q;
  logic [RT_W-1:0] rt_q;
  logic            rt_valid_q;
  logic            jump_q;
  logic [6:0]      lfsr;
  logic            tick;

  lfsr7 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign tick = (tick_q == TICK_LAST);

  // Sequencer with all outputs registered; tick counter restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      hold_q     <= '0;
      data_q     <= '0;
      rt_q       <= '0;
      rt_valid_q <= 1'b0;
      jump_q     <= 1'b0;
    end else begin
      rt_valid_q <= 1'b0;
      jump_q     <= 1'b0;
      tick_q     <= tick ? '0 : tick_q + 1'b1;
      case (state_q)
        IDLE: begin
          tick_q <= '0;
          // react is ignored here, so trigger wins a same-cycle tie
          if (bus.trigger) begin
            state_q <= LIGHTS_UP;
            data_q  <= '0;
          end
        end
        LIGHTS_UP: begin
          if (bus.react) begin
            jump_q  <= 1'b1;
            data_q  <= '0;
            state_q <= IDLE;
            tick_q  <= '0;
          end else if (tick) begin
            if (data_q == 8'hFF) begin
              hold_q  <= lfsr;
              state_q <= HOLD;
            end else begin
              data_q <= {data_q[6:0], 1'b1};
            end
          end
        end
        HOLD: begin
          // a press on the final hold tick still counts as a jump start
          if (bus.react) begin
            jump_q  <= 1'b1;
            data_q  <= '0;
            state_q <= IDLE;
            tick_q  <= '0;
          end else if (tick) begin
            hold_q <= hold_q - 1'b1;
            if (hold_q == 7'd1) begin
              data_q  <= '0;
              rt_q    <= '0;
              state_q <= TIMING;
            end
          end
        end
        TIMING: begin
          if (bus.react) begin
            rt_valid_q <= 1'b1;
            state_q    <= IDLE;
            tick_q     <= '0;
          end else if (rt_q != RT_MAX) begin
            rt_q <= rt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          data_q  <= '0;
          tick_q  <= '0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.rt_valid   = rt_valid_q;
  assign bus.rt_count   = rt_q;
  assign bus.jump_start = jump_q;

endmodule
